path_replayer: RTL
==================

# path_replayer

Replays a solved maze path move by move and tracks the resulting position. Sits directly downstream of the move Queue that the maze solver fills. On `run` it drains the Queue one 2-bit move per step, updates an (x, y) position from (0, 0) and streams each move out. It finishes with `done` if the path ends on the goal cell, or `fail` if a move leaves the grid or the moves run out before the goal.

## Interface
- `X_W`, 4: x coordinate width; grid is 2^X_W columns.
- `Y_W`, 4: y coordinate width; grid is 2^Y_W rows.
- `GOAL_X`, 15: goal column.
- `GOAL_Y`, 15: goal row.
- `CNT_W`, 9: step counter width; must hold Queue depth 256.
- `PACE`, 4: cycles per move when pacing is compiled in (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, **asynchronous, active-low**. Already decided.
- `run` in 1: start replay; level sampled in IDLE/DONE/FAIL.
- `q_empty` in 1: Queue empty flag.
- `q_data` in 2: Queue head move, first-word fall-through; valid when `q_empty`=0.
- `q_pop` out 1: combinational pop strobe to the Queue.
- `move_out` out 2: last replayed move (registered).
- `move_valid` out 1: 1-cycle pulse per replayed move.
- `pos_x` out X_W: current column.
- `pos_y` out Y_W: current row.
- `step_cnt` out CNT_W: moves replayed since start.
- `busy` out 1: high in STEP.
- `done` out 1: path ended on goal; held.
- `fail` out 1: error; held.

## Operation
- **Move encoding:**
  - 00 east: x+1
  - 01 south: y+1
  - 10 west: x−1
  - 11 north: y−1
- **FSM states:** IDLE, STEP, DONE, FAIL.
- **IDLE / DONE / FAIL, `run`=1:**
  - Clear position to (0, 0), `step_cnt`, `done` and `fail`.
  - Go to STEP.
- **STEP, `q_empty`=0 and pace tick:**
  - `q_pop`=1.
  - Next edge: position updated, `move_out`=`q_data`, `move_valid`=1, `step_cnt`+1.
- **Out-of-bounds move** (x+1 > 2^X_W−1, x−1 < 0, same for y):
  - The move is still popped.
  - Position is **not** updated; `step_cnt` still increments.
  - Go to FAIL.
- **STEP, `q_empty`=1:**
  - Position == (GOAL_X, GOAL_Y) → DONE.
  - Otherwise → FAIL.
  - An empty Queue at start therefore fails unless the goal is (0, 0).
- **Counter width:** `step_cnt` saturates at 2^CNT_W−1; it never wraps.
- **`run` while in STEP:** ignored.
- **Arithmetic:** position arithmetic is unsigned; the bound check is done on the (width+1)-bit result.

## Timing
- **Reset values:** all outputs 0, state IDLE. `q_pop` is forced low asynchronously because it decodes state.
- **Reset mid-replay:** the position is lost; moves left in the Queue are not popped.
- **Start latency:** `run` sampled at edge N → STEP from N; first `q_pop` in cycle N+1 (pace counter preloaded so the first move is not delayed).
- **Throughput:**
  - Without pacing: one move per cycle, back-to-back `q_pop`.
  - Position/outputs reflect a popped move one edge after the `q_pop` cycle.
- **End detection:** checked in the cycle `q_empty` is seen high in STEP. DONE/FAIL is entered at the following edge, and `done`/`fail` assert at that edge.
- **Flag hold:** `done` and `fail` are mutually exclusive and held until the next accepted `run` or reset.

## Configuration
- **Macro:** `PATH_REPLAYER_PACE_EN`.
- **Defined:**
  - A pace counter allows one pop every `PACE` cycles.
  - `move_valid` pulses once per move.
  - Position is held stable for `PACE` cycles, for a visible trace.
- **Undefined:**
  - No pace counter; one pop per cycle.
  - The `PACE` parameter is ignored.

## Structure
- **Shared package `maze_pkg`:**
  - Move encoding constants `MV_E`, `MV_S`, `MV_W`, `MV_N`.
  - The 2-bit `move_t` typedef.
  - The replayer state enum.
  - Shared with the solver, Stack and Queue.
- **Sub-module `pos_step`:** combinational next-position and out-of-bounds flag from (x, y, move).
- **Top level:** the FSM, pace counter and output registers stay in `path_replayer`.

## Test plan
- **Goal path:** Queue preloaded with 15×00 then 15×01, `run` pulse.
  - 30 `q_pop` strobes.
  - Final pos (15, 15), `step_cnt`=30, `done`=1, `fail`=0.
- **Left-edge error:** preload 01, 10, `run`.
  - After the second move: pos (0, 1), `fail`=1, `step_cnt`=2, `done`=0.
- **Moves run out before goal:** preload 00, 00, 01, `run`.
  - `fail`=1 with pos (2, 1).
  - No `q_pop` after empty.
- **Empty Queue:** `q_empty`=1, `run`.
  - FAIL one edge after entering STEP.
  - `q_pop` never asserted.
- **Reset mid-replay:** `rst` low after 5 of 30 moves.
  - All outputs 0 immediately, `q_pop`=0, state IDLE.
  - A new `run` replays the remaining 25 moves from (0, 0).
- **Pacing on and `run` while busy:** `PATH_REPLAYER_PACE_EN` defined, `PACE`=4.
  - `q_pop` spaced exactly 4 cycles apart.
  - `run` re-pulsed mid-replay has no effect.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze types: move encoding and replayer state, used by the solver,
// the Stack/Queue and the path replayer.
package maze_pkg;
  typedef logic [1:0] move_t;

  localparam move_t MV_E = 2'b00;  // x+1
  localparam move_t MV_S = 2'b01;  // y+1
  localparam move_t MV_W = 2'b10;  // x-1
  localparam move_t MV_N = 2'b11;  // y-1

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_DONE,
    ST_FAIL
  } rp_state_t;
endpackage

// File: rtl/pos_step.sv
// Combinational next position for one move, plus an out-of-bounds flag taken
// from the carry/borrow bit of a one-bit-wider result.
module pos_step
  import maze_pkg::*;
#(
  parameter int X_W = 4,
  parameter int Y_W = 4
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  move_t          mv,
  output logic [X_W-1:0] nx,
  output logic [Y_W-1:0] ny,
  output logic           oob
);
  logic [X_W:0] xe;
  logic [Y_W:0] ye;

  // widened add/subtract; the top bit is set on overflow or underflow
  always_comb begin
    xe = {1'b0, x};
    ye = {1'b0, y};
    case (mv)
      MV_E: xe = {1'b0, x} + {{X_W{1'b0}}, 1'b1};
      MV_S: ye = {1'b0, y} + {{Y_W{1'b0}}, 1'b1};
      MV_W: xe = {1'b0, x} - {{X_W{1'b0}}, 1'b1};
      MV_N: ye = {1'b0, y} - {{Y_W{1'b0}}, 1'b1};
      default: ;
    endcase
    nx  = xe[X_W-1:0];
    ny  = ye[Y_W-1:0];
    oob = xe[X_W] | ye[Y_W];
  end
endmodule

// File: rtl/path_replayer.sv
// Path replayer: drains the solver's move Queue one move per step, tracks the
// (x, y) position from (0, 0) and ends in DONE (goal reached) or FAIL (left the
// grid, or ran out of moves short of the goal).
// Optional macro PATH_REPLAYER_PACE_EN: one pop every PACE cycles so the
// position trace stays visible; without it moves replay back-to-back.
module path_replayer
  import maze_pkg::*;
#(
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  parameter int GOAL_X = 15,
  parameter int GOAL_Y = 15,
  parameter int CNT_W  = 9,
  parameter int PACE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             q_empty,
  input  move_t            q_data,
  output logic             q_pop,
  output move_t            move_out,
  output logic             move_valid,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             done,
  output logic             fail
);
  localparam logic [X_W-1:0]   GX      = X_W'(GOAL_X);
  localparam logic [Y_W-1:0]   GY      = Y_W'(GOAL_Y);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (PACE < 1) begin : g_pace_range
    $error("path_replayer: PACE must be >= 1");
  end

  rp_state_t      state;
  logic           pace_tick;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic           oob;
  logic           at_goal;

  pos_step #(.X_W(X_W), .Y_W(Y_W)) u_pos_step (
    .x   (pos_x),
    .y   (pos_y),
    .mv  (q_data),
    .nx  (nx),
    .ny  (ny),
    .oob (oob)
  );

  assign at_goal = (pos_x == GX) && (pos_y == GY);
  // state resets asynchronously, so the pop strobe drops with reset too
  assign busy    = (state == ST_STEP);
  assign q_pop   = busy & ~q_empty & pace_tick;

`ifdef PATH_REPLAYER_PACE_EN
  localparam int PC_W = (PACE > 1) ? $clog2(PACE) : 1;
  logic [PC_W-1:0] pace_cnt;

  assign pace_tick = (pace_cnt == '0);

  // held at zero outside STEP so the first move after run is not delayed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 pace_cnt <= '0;
    else if (!busy)           pace_cnt <= '0;
    else if (q_pop)           pace_cnt <= PC_W'(PACE - 1);
    else if (pace_cnt != '0)  pace_cnt <= pace_cnt - PC_W'(1);
  end
`else
  assign pace_tick = 1'b1;
`endif

  // replay FSM with registered position, counter, move stream and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      step_cnt   <= '0;
      move_out   <= MV_E;
      move_valid <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      move_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (run) begin
            pos_x    <= '0;
            pos_y    <= '0;
            step_cnt <= '0;
            done     <= 1'b0;
            fail     <= 1'b0;
            state    <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (q_empty) begin
            if (at_goal) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end
          end else if (pace_tick) begin
            move_out   <= q_data;
            move_valid <= 1'b1;
            if (step_cnt != CNT_MAX) step_cnt <= step_cnt + CNT_W'(1);
            // an off-grid move is consumed and counted but never applied
            if (oob) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              pos_x <= nx;
              pos_y <= ny;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
